lut_cfg_writer: RTL and testbench

LUT_CFG_WRITER -- requirements
Module: lut_cfg_writer

---
 rtl/lut_cfg_writer.sv | 146 ++++++++++++++
 tb/tb_lut_cfg_writer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_cfg_writer.sv
// lut_cfg_writer
// Reloads the INIT word of one of NUM_LUTS CFGLUT5-style configurable LUTs.
// Each request shifts a 32-bit word in MSB first. The word being shifted out
// of the LUT on its CDO pin is captured at the same time, so the LUT's previous
// content is returned with the completion pulse.
//
// Ports
//   clk        : sole clock, rising edge
//   rst_n      : asynchronous active-low reset
//   cfg_valid  : write request valid
//   cfg_ready  : request accepted when high together with cfg_valid (IDLE only)
//   cfg_addr   : target LUT index (>= NUM_LUTS flags an error)
//   cfg_data   : new INIT word
//   cdi        : serial config data, shared by all LUTs
//   ce         : per-LUT shift enable, at most one bit high
//   cdo        : per-LUT serial output (INIT[31])
//   rd_data    : previous INIT of the target LUT, held until the next completion
//   done       : one-cycle completion pulse
//   err        : out-of-range address on the completed request (only with done)
module lut_cfg_writer #(
    parameter int NUM_LUTS = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [2:0]          cfg_addr,
    input  logic [31:0]         cfg_data,
    output logic                cdi,
    output logic [NUM_LUTS-1:0] ce,
    input  logic [NUM_LUTS-1:0] cdo,
    output logic [31:0]         rd_data,
    output logic                done,
    output logic                err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] shift_q;
    logic [31:0] rback_q;
    logic [31:0] rd_data_q;
    logic [2:0]  sel_q;
    logic [4:0]  cnt_q;
    logic        err_q;

    logic                sel_ok;
    logic                cdo_sel;
    logic [NUM_LUTS-1:0] sel_onehot;

    assign sel_ok = ({29'd0, sel_q} < 32'(NUM_LUTS));

    // Decode the latched select once; an out-of-range select yields an
    // all-zero enable and a constant-zero readback bit.
    always_comb begin
        sel_onehot = '0;
        cdo_sel    = 1'b0;
        for (int i = 0; i < NUM_LUTS; i++) begin
            if (sel_q == 3'(i)) begin
                sel_onehot[i] = 1'b1;
                cdo_sel       = cdo[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Outputs decode from state only, so the asynchronous reset forcing
    // IDLE removes ce/cdi immediately, mid-shift included. cfg_ready is
    // additionally gated by rst_n so it stays low while reset is held.
    always_comb begin
        state_nxt = state;
        cfg_ready = 1'b0;
        cdi       = 1'b0;
        ce        = '0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                cfg_ready = rst_n;
                if (cfg_valid && rst_n) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                cdi = shift_q[31];
                ce  = sel_onehot;
                if (cnt_q == 5'd31) begin
                    state_nxt = FINISH;
                end
            end
            FINISH: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q   <= '0;
            rback_q   <= '0;
            rd_data_q <= '0;
            sel_q     <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_valid) begin
                        shift_q <= cfg_data;
                        sel_q   <= cfg_addr;
                        cnt_q   <= '0;
                        rback_q <= '0;
                    end
                end
                SHIFT: begin
                    shift_q <= {shift_q[30:0], 1'b0};
                    rback_q <= {rback_q[30:0], cdo_sel};
                    cnt_q   <= cnt_q + 5'd1;
                    // Publish the completed readback on the last shift edge
                    // so rd_data is already valid in FINISH and then holds.
                    if (cnt_q == 5'd31) begin
                        rd_data_q <= sel_ok ? {rback_q[30:0], cdo_sel} : 32'd0;
                        err_q     <= !sel_ok;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rd_data = rd_data_q;
    assign err     = done & err_q;

endmodule

// File: tb/tb_lut_cfg_writer.sv
module tb_lut_cfg_writer;

    localparam int NUM_LUTS = 2;

    logic                clk       = 1'b0;
    logic                rst_n     = 1'b0;
    logic                cfg_valid = 1'b0;
    logic                cfg_ready;
    logic [2:0]          cfg_addr  = 3'd0;
    logic [31:0]         cfg_data  = 32'd0;
    logic                cdi;
    logic [NUM_LUTS-1:0] ce;
    logic [NUM_LUTS-1:0] cdo;
    logic [31:0]         rd_data;
    logic                done;
    logic                err;

    lut_cfg_writer #(.NUM_LUTS(NUM_LUTS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cdi       (cdi),
        .ce        (ce),
        .cdo       (cdo),
        .rd_data   (rd_data),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioral CFGLUT5 shift chains
    logic        preload = 1'b1;
    logic [31:0] lut_init [NUM_LUTS];

    always @(posedge clk) begin
        for (int i = 0; i < NUM_LUTS; i++) begin
            if (preload) lut_init[i] <= (i == 1) ? 32'h0BADF00D : 32'h0;
            else if (ce[i]) lut_init[i] <= {lut_init[i][30:0], cdi};
        end
    end

    for (genvar g = 0; g < NUM_LUTS; g++) begin : g_cdo
        assign cdo[g] = lut_init[g][31];
    end

    typedef struct {
        logic [31:0]         rd;
        logic                err;
        logic                chk_rd;
        logic [31:0]         data;
        logic [NUM_LUTS-1:0] ce;
        int                  acc;
    } exp_t;

    exp_t q[$];
    int   n_cmp     = 0;
    int   n_bad     = 0;
    int   last_done = -100;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Presents a request and returns right after the accepting clock edge;
    // cfg_valid is left high so later stimulus decides what happens next.
    task automatic write(input logic [2:0] a, input logic [31:0] d, input logic [31:0] erd,
                         input logic eerr, input logic chk, input logic b2b);
        exp_t e;
        int   n;
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_addr  = a;
        cfg_data  = d;
        n = 0;
        while (!cfg_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cfg_ready) begin
            check("accept_timeout", {31'd0, cfg_ready}, 32'd1);
            cfg_valid = 1'b0;
            return;
        end
        if (b2b) check("b2b_accept_cycle", 32'(cyc), 32'(last_done + 1));
        e.rd     = erd;
        e.err    = eerr;
        e.chk_rd = chk;
        e.data   = d;
        e.ce     = eerr ? '0 : (NUM_LUTS'(1) << a);
        e.acc    = cyc;
        q.push_back(e);
        @(posedge clk);
    endtask

    task automatic finish_req();
        int n;
        @(negedge clk);
        cfg_valid = 1'b0;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            check("done_timeout", 32'(q.size()), 32'd0);
            q.delete();
        end
    endtask

    // Monitor: tracks enables, shifted data and ready, checks each completion
    int                  ce_cnt  = 0;
    int                  ce_bad  = 0;
    int                  rdy_low = 0;
    logic [31:0]         cdi_seq = 32'd0;
    logic [NUM_LUTS-1:0] exp_ce;
    exp_t                me;

    always @(negedge clk) begin
        if (!rst_n) begin
            ce_cnt  = 0;
            ce_bad  = 0;
            rdy_low = 0;
            cdi_seq = 32'd0;
        end else begin
            exp_ce = (q.size() > 0) ? q[0].ce : '0;
            if (ce != '0) begin
                ce_cnt++;
                cdi_seq = {cdi_seq[30:0], cdi};
                if (ce != exp_ce) ce_bad++;
            end
            if (!cfg_ready) rdy_low++;
            if (err && !done) check("err_without_done", {31'd0, err}, 32'd0);
            if (done) begin
                if (q.size() == 0) begin
                    check("unexpected_done", {31'd0, done}, 32'd0);
                end else begin
                    me = q.pop_front();
                    check("done_latency", 32'(cyc - me.acc), 32'd33);
                    check("err", {31'd0, err}, {31'd0, me.err});
                    if (me.chk_rd) check("rd_data", rd_data, me.rd);
                    check("ce_cycles", 32'(ce_cnt), me.err ? 32'd0 : 32'd32);
                    check("ce_wrong_bits", 32'(ce_bad), 32'd0);
                    if (!me.err) check("cdi_msb_first", cdi_seq, me.data);
                    check("ready_low_cycles", 32'(rdy_low), 32'd33);
                    check("ce_in_finish", 32'(ce), 32'd0);
                end
                last_done = cyc;
                ce_cnt    = 0;
                ce_bad    = 0;
                rdy_low   = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {31'd0, cfg_ready}, 32'd0);
        check("rst_ce", 32'(ce), 32'd0);
        check("rst_cdi", {31'd0, cdi}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        preload = 1'b0;
        rst_n   = 1'b1;
        @(negedge clk);
        check("ready_after_rst", {31'd0, cfg_ready}, 32'd1);

        // Basic write to LUT0
        write(3'd0, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1, 1'b0);
        finish_req();
        check("lut0_after_w1", lut_init[0], 32'hDEADBEEF);
        check("lut1_after_w1", lut_init[1], 32'h0BADF00D);

        // Back-to-back writes to LUT1
        write(3'd1, 32'h12345678, 32'h0BADF00D, 1'b0, 1'b1, 1'b0);
        write(3'd1, 32'hA5A5A5A5, 32'h12345678, 1'b0, 1'b1, 1'b1);
        finish_req();
        check("lut1_after_b2b", lut_init[1], 32'hA5A5A5A5);
        check("lut0_after_b2b", lut_init[0], 32'hDEADBEEF);

        // Out-of-range address
        write(3'd5, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b1, 1'b0);
        finish_req();
        check("lut0_after_err", lut_init[0], 32'hDEADBEEF);
        check("lut1_after_err", lut_init[1], 32'hA5A5A5A5);

        // Valid held with changing data during the shift; walking one LSB
        write(3'd0, 32'h00000001, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            cfg_data = $urandom;
            cfg_addr = 3'(i);
        end
        finish_req();
        check("lut0_after_hold", lut_init[0], 32'h00000001);

        // Walking one MSB
        write(3'd0, 32'h80000000, 32'h00000001, 1'b0, 1'b1, 1'b0);
        finish_req();
        check("lut0_after_walk", lut_init[0], 32'h80000000);

        // Reset in the middle of a shift
        write(3'd0, 32'hFFFF0000, 32'h0, 1'b0, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        q.delete();
        #1;
        check("abort_ce_async", 32'(ce), 32'd0);
        @(negedge clk);
        check("abort_ready", {31'd0, cfg_ready}, 32'd0);
        check("abort_ce", 32'(ce), 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_abort", {31'd0, cfg_ready}, 32'd1);
        repeat (40) @(negedge clk);
        write(3'd0, 32'h0000FFFF, 32'h0, 1'b0, 1'b0, 1'b0);
        finish_req();
        check("lut0_after_abort", lut_init[0], 32'h0000FFFF);
        check("lut1_after_abort", lut_init[1], 32'hA5A5A5A5);

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
